sigsequencer: RTL and testbench
===============================

// Module: sigsequencer
// PURPOSE
// Upstream stage of the correlator signal path. Buffers raw antenna IQ
// samples arriving on a valid/ready stream and replays each sample TRATE
// times, tagging every beat with a time-slot address (taddr_o) and window
// framing flags (first/next/last), as sigsource expects.
// Groups LOOP samples into one correlation window.
// PARAMETERS
// WIDTH  32  number of antennas; width of the I and Q sample words
// TRATE  30  time-multiplexing rate; beats emitted per sample (>=2)
// LOOP   4   samples per correlation window (>=1)
// TBITS  $clog2(TRATE)  localparam; taddr_o width
// LBITS  $clog2(LOOP)+1 localparam; window sample-counter width
// PORTS
// clock    in   1      system clock; all state changes on rising edge
// reset    in   1      asynchronous, active-high reset
// s_valid  in   1      input sample valid
// s_ready  out  1      input sample accepted when s_valid & s_ready
// s_idata  in   WIDTH  in-phase bits, one per antenna
// s_qdata  in   WIDTH  quadrature bits, one per antenna
// valid_o  out  1      output beat valid
// first_o  out  1      first beat of a window
// next_o   out  1      last beat of a sample, i.e. sample boundary
// last_o   out  1      final beat of a window
// taddr_o  out  TBITS  time-slot address of the beat, 0..TRATE-1
// idata_o  out  WIDTH  in-phase word of the current sample
// qdata_o  out  WIDTH  quadrature word of the current sample
// BEHAVIOUR
// - Reset, asynchronous: all outputs 0, s_ready 0, FIFO empty,
//   tcount 0, lcount 0. After release, s_ready is 1 from the first edge.
// - Input buffer: 2-entry FIFO, registered occupancy.
//   s_ready = !full. s_ready does not depend on pop in the same cycle.
//   A push and a pop in the same cycle keep occupancy unchanged.
// - Latency: a sample accepted at edge k, into an empty FIFO with the
//   sequencer idle, drives its beat taddr=0 on the outputs after edge k+1.
// - Beat generator: on every edge where FIFO head is valid, registered
//   outputs load valid_o=1, taddr_o=tcount, and idata_o/qdata_o=head.
// - tcount increments per beat. At tcount==TRATE-1 it wraps to 0 and the
//   head is popped.
// - FIFO empty at a beat slot: valid_o=0, all flags 0, and data holds its
//   previous value. tcount and lcount do not change. No beat is dropped
//   or duplicated, and window position is preserved across the gap.
// - Flags (valid with valid_o only):
//   first_o=1 iff tcount==0 and lcount==0.
//   next_o=1 iff tcount==TRATE-1.
//   last_o=1 iff tcount==TRATE-1 and lcount==LOOP-1.
// - lcount increments on each pop and wraps to 0 after LOOP-1.
//   LOOP==1: first_o and last_o assert on every sample.
// - No downstream backpressure: once valid, beats are emitted on
//   consecutive cycles while data exists.
// - Sequencer states: IDLE (FIFO empty, tcount==0) and RUN (emitting).
//   IDLE->RUN on non-empty. RUN->IDLE when a pop leaves the FIFO empty.
//   A push on the pop edge keeps RUN and emits taddr=0 of the new sample
//   on the next cycle, with no bubble.
// - Reset mid-window: async reset clears everything at once, any partial
//   window is discarded, and the next accepted sample starts a new window
//   (first_o on its taddr 0).
// TESTING
// - Reset, then one sample I=0xA5A5A5A5 Q=0x0F0F0F0F: 30 beats, taddr
//   0..29, data constant, first_o@0, next_o@29, last_o=0; then valid_o=0.
// - Four back-to-back samples: 120 consecutive valid beats with no gap,
//   first_o only on beat 0, next_o on beats 29/59/89/119, last_o on 119.
// - s_valid held high: s_ready drops after the FIFO holds 2 entries, reasserts
//   the cycle after a pop, and all samples emerge in order.
// - Starvation between samples 2 and 3: bubble of valid_o=0. Sample 3 then
//   starts at taddr 0 with first_o=0, and sample 4 ends with last_o=1.
// - Reset asserted at beat 15 of sample 2: outputs 0 asynchronously. The next
//   sample after release gives first_o=1 at taddr 0, and old data never appears.
// - TRATE=3, LOOP=1: every sample gives taddr 0,1,2 with first_o@0 and
//   next_o and last_o both @2.

Source files
------------

// File: rtl/sigsequencer.sv
// Sample sequencer: buffers IQ samples in a 2-entry FIFO and replays each one
// TRATE times with time-slot address and window framing flags.
module sigsequencer #(
  parameter int WIDTH = 32,
  parameter int TRATE = 30,
  parameter int LOOP  = 4,
  localparam int TBITS = $clog2(TRATE),
  localparam int LBITS = $clog2(LOOP) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_idata,
  input  logic [WIDTH-1:0] s_qdata,
  output logic             valid_o,
  output logic             first_o,
  output logic             next_o,
  output logic             last_o,
  output logic [TBITS-1:0] taddr_o,
  output logic [WIDTH-1:0] idata_o,
  output logic [WIDTH-1:0] qdata_o
);

  localparam logic [TBITS-1:0] TMAX = TBITS'(TRATE - 1);
  localparam logic [LBITS-1:0] LMAX = LBITS'(LOOP - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] imem_q [2];
  logic [WIDTH-1:0] imem_d [2];
  logic [WIDTH-1:0] qmem_q [2];
  logic [WIDTH-1:0] qmem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic [TBITS-1:0] tcount_q, tcount_d;
  logic [LBITS-1:0] lcount_q, lcount_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             next_q, next_d;
  logic             last_q, last_d;
  logic [TBITS-1:0] taddr_q, taddr_d;
  logic [WIDTH-1:0] idata_q, idata_d;
  logic [WIDTH-1:0] qdata_q, qdata_d;

  logic push_s;
  logic pop_s;
  logic beat_s;

  // FIFO bookkeeping, beat counters and next-state logic
  always_comb begin
    state_d  = state_q;
    imem_d   = imem_q;
    qmem_d   = qmem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tcount_d = tcount_q;
    lcount_d = lcount_q;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    next_d   = 1'b0;
    last_d   = 1'b0;
    taddr_d  = taddr_q;
    idata_d  = idata_q;
    qdata_d  = qdata_q;

    // ready is registered, so acceptance never depends on this cycle's pop
    push_s = s_valid & ready_q;
    beat_s = (state_q == RUN);
    pop_s  = beat_s && (tcount_q == TMAX);

    if (push_s) begin
      imem_d[wr_ptr_q] = s_idata;
      qmem_d[wr_ptr_q] = s_qdata;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
      lcount_d = (lcount_q == LMAX) ? '0 : lcount_q + LBITS'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    ready_d = (count_d != 2'd2);

    if (beat_s) begin
      tcount_d = (tcount_q == TMAX) ? '0 : tcount_q + TBITS'(1'b1);
      valid_d  = 1'b1;
      first_d  = (tcount_q == '0) && (lcount_q == '0);
      next_d   = (tcount_q == TMAX);
      last_d   = (tcount_q == TMAX) && (lcount_q == LMAX);
      taddr_d  = tcount_q;
      idata_d  = imem_q[rd_ptr_q];
      qdata_d  = qmem_q[rd_ptr_q];
    end else begin
      tcount_d = tcount_q;
    end

    case (state_q)
      IDLE:    state_d = push_s ? RUN : IDLE;
      RUN:     state_d = (pop_s && (count_d == 2'd0)) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      imem_q[0] <= '0;
      imem_q[1] <= '0;
      qmem_q[0] <= '0;
      qmem_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
      tcount_q  <= '0;
      lcount_q  <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      next_q    <= 1'b0;
      last_q    <= 1'b0;
      taddr_q   <= '0;
      idata_q   <= '0;
      qdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      imem_q    <= imem_d;
      qmem_q    <= qmem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      tcount_q  <= tcount_d;
      lcount_q  <= lcount_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      next_q    <= next_d;
      last_q    <= last_d;
      taddr_q   <= taddr_d;
      idata_q   <= idata_d;
      qdata_q   <= qdata_d;
    end
  end

  assign s_ready = ready_q;
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign next_o  = next_q;
  assign last_o  = last_q;
  assign taddr_o = taddr_q;
  assign idata_o = idata_q;
  assign qdata_o = qdata_q;

endmodule

// File: tb/tb_sigsequencer.sv
// Directed bench for sigsequencer: a cycle table on a TRATE=3/LOOP=1 copy plus
// multi-cycle sequences on the default 30/4 configuration.
module tb_sigsequencer;

  logic        clk;
  logic        rst, rst2;
  logic        s_valid, s_ready;
  logic [31:0] s_idata, s_qdata;
  logic        valid_o, first_o, next_o, last_o;
  logic [4:0]  taddr_o;
  logic [31:0] idata_o, qdata_o;

  logic        sv2, rdy2, val2, f2, n2, l2;
  logic [31:0] si2, sq2, i2, q2;
  logic [1:0]  t2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  typedef struct {
    int          cyc;
    logic        f, n, l;
    logic [4:0]  t;
    logic [31:0] i, q;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic        vin;
    logic [31:0] di, dq;
    logic        e_rdy, e_val, e_f, e_n, e_l;
    logic [1:0]  e_t;
    logic [31:0] e_i, e_q;
  } vec_t;
  vec_t tv [12];

  logic [31:0] si [4];
  logic [31:0] sq [4];

  sigsequencer u_dut (
    .clock(clk), .reset(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_idata(s_idata), .s_qdata(s_qdata), .valid_o(valid_o), .first_o(first_o),
    .next_o(next_o), .last_o(last_o), .taddr_o(taddr_o), .idata_o(idata_o),
    .qdata_o(qdata_o)
  );

  sigsequencer #(.WIDTH(32), .TRATE(3), .LOOP(1)) u_small (
    .clock(clk), .reset(rst2), .s_valid(sv2), .s_ready(rdy2),
    .s_idata(si2), .s_qdata(sq2), .valid_o(val2), .first_o(f2),
    .next_o(n2), .last_o(l2), .taddr_o(t2), .idata_o(i2), .qdata_o(q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && valid_o)
      beats.push_back('{cyc, first_o, next_o, last_o, taddr_o, idata_o, qdata_o});
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] q);
    int c;
    c = 0;
    s_valid = 1'b1;
    s_idata = i;
    s_qdata = q;
    while (!s_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("accept_wait", {95'd0, c < 500}, 96'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    s_valid = 1'b0;
  endtask

  // Compare the recorded beats against n samples from si/sq, window starting fresh
  task automatic check_beats(input string name, input int n, input int gap);
    int brk, brk_at, k, t;
    logic ef, en, el;
    chk({name, "_count"}, 96'(beats.size()), 96'(n * 30));
    for (int j = 0; j < beats.size() && j < n * 30; j++) begin
      k  = j / 30;
      t  = j % 30;
      ef = (t == 0) && (k % 4 == 0);
      en = (t == 29);
      el = (t == 29) && (k % 4 == 3);
      chk($sformatf("%s_beat%0d", name, j),
          {beats[j].f, beats[j].n, beats[j].l, beats[j].t, beats[j].i, beats[j].q},
          {ef, en, el, 5'(t), si[k], sq[k]});
    end
    brk = 0;
    brk_at = -1;
    for (int j = 1; j < beats.size(); j++) begin
      if (beats[j].cyc != beats[j-1].cyc + 1) begin
        brk++;
        if (brk_at < 0) brk_at = j;
      end
    end
    chk({name, "_gaps"}, {32'd0, 32'(brk), 32'(brk_at)},
        {32'd0, (gap >= 0) ? 32'd1 : 32'd0, 32'(gap)});
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, first_run, low_run, found;
    logic pend, seen_next;
    logic [31:0] ai, aq, bi, bq, ci, cq;

    rst = 1'b1; rst2 = 1'b1;
    s_valid = 1'b0; s_idata = 32'h0; s_qdata = 32'h0;
    sv2 = 1'b0; si2 = 32'h0; sq2 = 32'h0;

    ai = 32'hA0A0_0001; aq = 32'h0A0A_0001;
    bi = 32'hB0B0_0002; bq = 32'h0B0B_0002;
    ci = 32'hC0C0_0003; cq = 32'h0C0C_0003;
    tv[0]  = '{1'b1, ai, aq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    tv[1]  = '{1'b1, ai, aq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    tv[2]  = '{1'b0, ai, aq, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, ai, aq};
    tv[3]  = '{1'b1, bi, bq, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, ai, aq};
    tv[4]  = '{1'b1, ci, cq, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, ai, aq};
    tv[5]  = '{1'b1, ci, cq, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, bi, bq};
    tv[6]  = '{1'b0, ci, cq, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, bi, bq};
    tv[7]  = '{1'b0, ci, cq, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, bi, bq};
    tv[8]  = '{1'b0, ci, cq, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, ci, cq};
    tv[9]  = '{1'b0, ci, cq, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, ci, cq};
    tv[10] = '{1'b0, ci, cq, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, ci, cq};
    tv[11] = '{1'b0, ci, cq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ci, cq};

    @(negedge clk);
    chk("rst_small", {rdy2, val2, f2, n2, l2, t2, i2, q2}, 96'd0);
    chk("rst_main", {s_ready, valid_o, first_o, next_o, last_o, taddr_o, idata_o, qdata_o}, 96'd0);
    @(negedge clk);
    rst2 = 1'b0;

    // TRATE=3, LOOP=1 cycle table
    for (int k = 0; k < 12; k++) begin
      sv2 = tv[k].vin;
      si2 = tv[k].di;
      sq2 = tv[k].dq;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", k), {rdy2, val2, f2, n2, l2, (val2 ? t2 : 2'd0)},
          {tv[k].e_rdy, tv[k].e_val, tv[k].e_f, tv[k].e_n, tv[k].e_l, tv[k].e_t});
      chk($sformatf("tbl%0d_data", k), {i2, q2}, {tv[k].e_i, tv[k].e_q});
    end
    sv2 = 1'b0;

    // Single sample: 30 beats, latency of one cycle after acceptance
    do_reset();
    si[0] = 32'hA5A5_A5A5; sq[0] = 32'h0F0F_0F0F;
    send(si[0], sq[0]);
    repeat (45) @(negedge clk);
    check_beats("single", 1, -1);
    if (beats.size() > 0) chk("latency", 96'(beats[0].cyc), 96'(acc_cyc + 1));
    else chk("latency", 96'd0, 96'd1);

    // Four back-to-back samples form one window with no gaps
    do_reset();
    for (int k = 0; k < 4; k++) begin
      si[k] = 32'h1111_0000 + 32'(k);
      sq[k] = 32'h2222_0000 + 32'(k);
    end
    for (int k = 0; k < 4; k++) send(si[k], sq[k]);
    repeat (100) @(negedge clk);
    check_beats("b2b", 4, -1);

    // s_valid held high: ready drops while full and returns right after a pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      si[k] = 32'h3333_0000 + 32'(k);
      sq[k] = 32'h4444_0000 + 32'(k);
    end
    idx = 0; pend = 1'b0; first_run = -1; low_run = 0; seen_next = 1'b0;
    for (int c = 0; c < 400 && idx < 4; c++) begin
      if (pend) begin
        idx++;
        pend = 1'b0;
      end
      if (idx < 4) begin
        s_valid = 1'b1;
        s_idata = si[idx];
        s_qdata = sq[idx];
        if (s_ready) pend = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      if (idx >= 2 && first_run < 0) begin
        if (!s_ready) low_run++;
        else first_run = low_run;
      end
      if (valid_o && next_o && !seen_next) begin
        seen_next = 1'b1;
        chk("ready_after_pop", {95'd0, s_ready}, 96'd1);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("held_accepts", 96'(idx), 96'd4);
    chk("ready_low_run", 96'(first_run), 96'd29);
    repeat (100) @(negedge clk);
    check_beats("held", 4, -1);

    // Starvation between samples 2 and 3 keeps the window position
    do_reset();
    for (int k = 0; k < 4; k++) begin
      si[k] = 32'h5555_0000 + 32'(k);
      sq[k] = 32'h6666_0000 + 32'(k);
    end
    send(si[0], sq[0]);
    send(si[1], sq[1]);
    repeat (70) @(negedge clk);
    send(si[2], sq[2]);
    send(si[3], sq[3]);
    repeat (70) @(negedge clk);
    check_beats("starve", 4, 60);

    // Asynchronous reset at beat 15 of sample 2, then a fresh window
    do_reset();
    send(32'h7777_0001, 32'h8888_0001);
    send(32'h7777_0002, 32'h8888_0002);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (valid_o && idata_o == 32'h7777_0002 && taddr_o == 5'd15) found = 1;
    end
    chk("mid_found", 96'(found), 96'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", {s_ready, valid_o, first_o, next_o, last_o, taddr_o, idata_o, qdata_o}, 96'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
    si[0] = 32'h9999_0001; sq[0] = 32'hAAAA_0001;
    send(si[0], sq[0]);
    repeat (45) @(negedge clk);
    check_beats("post_rst", 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
